asic_ao_pipe: RTL

ASIC_AO_PIPE -- requirements
Module: asic_ao_pipe

---
 rtl/asic_ao_pkg.sv | 21 ++
 rtl/asic_ao_stage.sv | 42 ++++
 rtl/asic_ao_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/asic_ao_pkg.sv
// asic_ao_pkg: shared constants and helpers for the AND-OR pipeline.
//   - Parameter limits for N (terms), K (inputs per term), W (lanes), STAGES.
//   - data_idx(): flat bit position of operand (n,k,w) inside in_data.
package asic_ao_pkg;

  localparam int N_MIN      = 1;
  localparam int N_MAX      = 8;
  localparam int K_MIN      = 1;
  localparam int K_MAX      = 8;
  localparam int W_MIN      = 1;
  localparam int W_MAX      = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  // Operands are packed term-major, then input, then lane.
  function automatic int data_idx(input int n, input int k, input int w,
                                  input int kk, input int ww);
    return (n * kk + k) * ww + w;
  endfunction

endpackage

// File: rtl/asic_ao_stage.sv
// asic_ao_stage: one valid/ready pipeline register slice.
// Ports:
//   clk, nreset            clock, async active-low reset
//   up_valid, up_data      incoming item from the previous slice (or input)
//   down_advance           next slice (or output side) can take an item
//   valid, data            item held by this slice
//   advance                this slice moves this cycle (empty or draining)
module asic_ao_stage
  import asic_ao_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_advance,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         advance
);

  assign advance = !valid || down_advance;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= up_valid;
    end
  end

  // Data only moves when a real item arrives; a bubble leaves it untouched.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      data <= '0;
    end else if (advance && up_valid) begin
      data <= up_data;
    end
  end

endmodule

// File: rtl/asic_ao_pipe.sv
// asic_ao_pipe: pipelined W-lane sum-of-products (OR of N ANDs of K inputs).
// Ports:
//   clk, nreset            clock, async active-low reset
//   in_valid, in_ready     input handshake; transfer when both high
//   in_data [N*K*W]        operand (n,k,w) at bit (n*K+k)*W+w
//   term_en [N]            per-term enable, present only with ASIC_AO_PIPE_MASK_EN
//   out_valid, out_ready   output handshake
//   out_z [W]              registered result
//   busy                   any stage holds valid data
// Build option: define ASIC_AO_PIPE_MASK_EN to add term_en; otherwise all
// terms are always enabled.
module asic_ao_pipe
  import asic_ao_pkg::*;
#(
  parameter int    N      = 2,
  parameter int    K      = 3,
  parameter int    W      = 1,
  parameter int    STAGES = 1,
  parameter string PROP   = "DEFAULT"
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K*W-1:0] in_data,
`ifdef ASIC_AO_PIPE_MASK_EN
  input  logic [N-1:0]     term_en,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_z,
  output logic             busy
);

  if (N < N_MIN || N > N_MAX || K < K_MIN || K > K_MAX ||
      W < W_MIN || W > W_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX)
  begin : g_bad_cfg
    $error("asic_ao_pipe(%s): parameter out of range", PROP);
  end

  logic [N-1:0] en;
`ifdef ASIC_AO_PIPE_MASK_EN
  assign en = term_en;
`else
  assign en = '1;
`endif

  logic [W-1:0] sop;

  always_comb begin
    sop = '0;
    for (int w = 0; w < W; w++) begin
      for (int n = 0; n < N; n++) begin : g_term
        logic term;
        term = en[n];
        for (int k = 0; k < K; k++) begin
          term = term & in_data[data_idx(n, k, w, K, W)];
        end
        sop[w] = sop[w] | term;
      end
    end
  end

  // Chains are indexed by slice boundary: [0] is the input side,
  // [STAGES] is the output side.
  logic [STAGES:0] v_chain;
  logic [STAGES:0] adv_chain;
  logic [W-1:0]    d_chain [STAGES+1];

  assign v_chain[0]         = in_valid;
  assign d_chain[0]         = sop;
  assign adv_chain[STAGES]  = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    asic_ao_stage #(.W(W)) u_stage (
      .clk          (clk),
      .nreset       (nreset),
      .up_valid     (v_chain[i]),
      .up_data      (d_chain[i]),
      .down_advance (adv_chain[i+1]),
      .valid        (v_chain[i+1]),
      .data         (d_chain[i+1]),
      .advance      (adv_chain[i])
    );
  end

  assign in_ready  = adv_chain[0];
  assign out_valid = v_chain[STAGES];
  assign out_z     = d_chain[STAGES];
  assign busy      = |v_chain[STAGES:1];

endmodule
